// File: rtl/serial_adder_fsm.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB-first through one full-adder
// cell with a registered carry. Define SERIAL_ADDER_SUB_EN to add a-b via a sub port.
module serial_adder_fsm #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic             sum_bit,
    output logic             sum_bit_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic            carry;
    logic [CW-1:0]   count;
    logic            s_bit;
    logic            carry_next;
    logic            final_carry;

`ifdef SERIAL_ADDER_SUB_EN
    logic            sub_q;
    // Subtraction is a + ~b + 1; the final carry is the inverted borrow.
    assign final_carry = sub_q ? ~carry_next : carry_next;
`else
    assign final_carry = carry_next;
`endif

    // Single full-adder cell shared by every bit position.
    assign s_bit      = a_sh[0] ^ b_sh[0] ^ carry;
    assign carry_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // NOTE: every register, including the operand shift registers, is cleared on
    // reset so a discarded partial result can never leak into a later operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            a_sh          <= '0;
            b_sh          <= '0;
            carry         <= 1'b0;
            count         <= '0;
            sum_bit       <= 1'b0;
            sum_bit_valid <= 1'b0;
            sum           <= '0;
            carry_out     <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q         <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every register samples
            // the pre-edge values regardless of statement order.
            sum_bit_valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh      <= a;
                        count     <= '0;
                        sum       <= '0;
                        carry_out <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
                        b_sh      <= sub ? ~b : b;
                        carry     <= sub;
                        sub_q     <= sub;
`else
                        b_sh      <= b;
                        carry     <= 1'b0;
`endif
                        state     <= RUN;
                    end else begin
                        state     <= IDLE;
                    end
                end
                RUN: begin
                    if (en) begin
                        a_sh          <= a_sh >> 1;
                        b_sh          <= b_sh >> 1;
                        carry         <= carry_next;
                        sum           <= {s_bit, sum[WIDTH-1:1]};
                        sum_bit       <= s_bit;
                        sum_bit_valid <= 1'b1;
                        count         <= count + 1'b1;
                        if (count == LAST_BIT) begin
                            carry_out <= final_carry;
                            state     <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
